f_pc_unit: RTL and testbench

F_PC_UNIT -- requirements
Module: f_pc_unit

---
 rtl/f_pc_unit.sv | 81 ++++++++
 tb/tb_f_pc_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/f_pc_unit.sv
// rtl/f_pc_unit.sv - F-stage program counter with branch/jump redirect, ERET and exception entry
// Registered fetch PC plus combinational delay-slot flag and fetch address-error code.
module f_pc_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_sel,
  input  logic        bflag,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  output logic [31:0] pc,
  output logic        f_bd,
  output logic [4:0]  f_exc
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        fetch_bad;

  always_comb begin
    seq_pc    = pc_q + 32'd4;
    br_target = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    j_target  = {d_pc[31:28], d_imm26, 2'b00};
  end

  // Redirects are resolved in D, so the delay-slot instruction already in F is
  // fetched this cycle and the target lands in pc on the next edge.
  always_comb begin
    pc_d = seq_pc;
    if (reset) begin
      pc_d = PC_RESET;
    end else if (req) begin
      pc_d = EXC_ENTRY;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret) begin
      pc_d = epc;
    end else begin
      unique case (npc_sel)
        NPC_BR:  pc_d = bflag ? br_target : seq_pc;
        NPC_J:   pc_d = j_target;
        NPC_JR:  pc_d = d_rs;
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  // The slot exists for not-taken branches too, hence no dependence on bflag.
  always_comb begin
    fetch_bad = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
    f_bd      = (npc_sel != NPC_SEQ) && !eret;
    f_exc     = fetch_bad ? EXC_ADEL : EXC_NONE;
    pc        = pc_q;
  end

endmodule

// File: tb/tb_f_pc_unit.sv
// tb/tb_f_pc_unit.sv - directed self-checking bench for f_pc_unit
module tb_f_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [1:0]  npc_sel;
  logic        bflag;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic [31:0] pc;
  logic        f_bd;
  logic [4:0]  f_exc;

  int total;
  int bad;

  f_pc_unit dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .req     (req),
    .eret    (eret),
    .epc     (epc),
    .npc_sel (npc_sel),
    .bflag   (bflag),
    .d_pc    (d_pc),
    .d_imm16 (d_imm16),
    .d_imm26 (d_imm26),
    .d_rs    (d_rs),
    .pc      (pc),
    .f_bd    (f_bd),
    .f_exc   (f_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    req     = 1'b0;
    eret    = 1'b0;
    epc     = 32'h0;
    npc_sel = 2'd0;
    bflag   = 1'b0;
    d_pc    = 32'h0;
    d_imm16 = 16'h0;
    d_imm26 = 26'h0;
    d_rs    = 32'h0;

    step();
    check("reset_pc", pc, 32'h3000);
    check("reset_exc", {27'd0, f_exc}, 32'd0);
    check("reset_bd", {31'd0, f_bd}, 32'd0);

    reset = 1'b0;
    step(); check("seq1", pc, 32'h3004);
    step(); check("seq2", pc, 32'h3008);
    step(); check("seq3", pc, 32'h300C);
    step(); step(); check("seq5", pc, 32'h3014);

    d_pc = 32'h3010; d_imm16 = 16'hFFFC; npc_sel = 2'd1; bflag = 1'b1;
    #1 check("br_taken_bd", {31'd0, f_bd}, 32'd1);
    step(); check("br_taken_pc", pc, 32'h3004);

    npc_sel = 2'd0;
    repeat (4) step();
    check("back_to_3014", pc, 32'h3014);
    npc_sel = 2'd1; bflag = 1'b0;
    #1 check("br_nt_bd", {31'd0, f_bd}, 32'd1);
    step(); check("br_nt_pc", pc, 32'h3018);

    npc_sel = 2'd0;
    step(); step(); check("at_3020", pc, 32'h3020);

    stall = 1'b1; npc_sel = 2'd2; d_pc = 32'h3020; d_imm26 = 26'h0000C10;
    step(); check("stall1", pc, 32'h3020);
    step(); check("stall2", pc, 32'h3020);
    check("stall_bd", {31'd0, f_bd}, 32'd1);
    step(); check("stall3", pc, 32'h3020);
    stall = 1'b0;
    step(); check("j_after_stall", pc, 32'h3040);

    req = 1'b1; stall = 1'b1; eret = 1'b1; epc = 32'h3100; npc_sel = 2'd3; d_rs = 32'h5000;
    step(); check("req_prio", pc, 32'h4180);
    req = 1'b0;
    step(); check("stall_blocks_eret", pc, 32'h4180);
    stall = 1'b0; eret = 1'b0;

    npc_sel = 2'd3; d_rs = 32'h3002;
    step(); check("jr_mis_pc", pc, 32'h3002);
    check("jr_mis_exc", {27'd0, f_exc}, 32'd4);
    d_rs = 32'h7000;
    step(); check("jr_hi_exc", {27'd0, f_exc}, 32'd4);
    d_rs = 32'h6FFC;
    step(); check("jr_top_pc", pc, 32'h6FFC);
    check("jr_top_exc", {27'd0, f_exc}, 32'd0);
    d_rs = 32'h2FFC;
    step(); check("jr_lo_exc", {27'd0, f_exc}, 32'd4);
    npc_sel = 2'd0;
    step(); check("adel_no_effect_pc", pc, 32'h3000);
    check("text_lo_exc", {27'd0, f_exc}, 32'd0);

    eret = 1'b1; epc = 32'h3100; npc_sel = 2'd0;
    #1 check("eret_bd", {31'd0, f_bd}, 32'd0);
    step(); check("eret_pc", pc, 32'h3100);
    npc_sel = 2'd2; epc = 32'h3200; d_pc = 32'h3100; d_imm26 = 26'h0000C40;
    #1 check("eret_j_bd", {31'd0, f_bd}, 32'd0);
    step(); check("eret_over_j", pc, 32'h3200);
    npc_sel = 2'd0; reset = 1'b1;
    step(); check("reset_over_eret", pc, 32'h3000);
    reset = 1'b0; eret = 1'b0;

    npc_sel = 2'd3; d_rs = 32'hFFFF_FFFC;
    step(); check("top_pc", pc, 32'hFFFF_FFFC);
    npc_sel = 2'd0;
    step(); check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_exc", {27'd0, f_exc}, 32'd4);

    stall = 1'b1; npc_sel = 2'd2; reset = 1'b1;
    step(); check("reset_mid_stall", pc, 32'h3000);
    reset = 1'b0; stall = 1'b0; npc_sel = 2'd0;
    step(); check("after_reset_seq", pc, 32'h3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
